sap_control_sequencer: RTL
==========================

// Module: sap_control_sequencer
// PURPOSE
//  T-state controller for the SAP-U 8-bit bus machine. Steps a 6-phase ring (T1..T6) and decodes the
//  IR opcode into one control word. The control word drives the active-low load (G1/G2) and
//  output-enable (M/N) pins of the sn54173-based PC, MAR, IR, A, B and OUT registers, plus RAM/ALU.
//  Guarantees at most one bus driver per cycle; the only block that sequences bus transfers.
// PARAMETERS
//  OPW      4   opcode width (IR upper nibble)
//  CW_W     12  control-word width (bit map in package)
//  T_LAST   6   last T-state of every instruction
// PORTS
//  clk      in   1     system clock, all state advances on rising edge
//  clr_n    in   1     asynchronous active-low reset
//  run      in   1     1 = fetch/execute; 0 = stop at next T1 boundary
//  opcode   in   OPW   IR[7:4], valid from T4 onward
//  cw       out  CW_W  control word (bit map below)
//  tstate   out  3     0 = idle/halted, 1..6 = current T-state
//  halted   out  1     1 after HLT executed
// BEHAVIOUR
//  cw bit map, MSB..LSB:
//   pc_inc, pc_out_n, mar_load_n, ram_out_n, ir_load_n, ir_out_n, a_load_n, a_out_n,
//   b_load_n, alu_out_n, alu_sub, out_load_n.
//   *_n bits are active-low. pc_inc and alu_sub are active-high.
//  CW_IDLE = 12'b0111_1111_1101: all *_n = 1, pc_inc = 0, alu_sub = 0.
//  Reset (clr_n = 0, asynchronous, also mid-instruction):
//   state = IDLE, tstate = 0, halted = 0, cw = CW_IDLE immediately.
//  States: IDLE, RUN (tstate 1..6), HALT.
//   IDLE -> RUN/T1 at the rising edge where run = 1.
//   RUN advances T(k) -> T(k+1) each edge.
//   At T6: next = T1 if run = 1, else IDLE.
//   run = 0 mid-instruction does not abort; the instruction completes through T6.
//  cw is combinational from (state, tstate, opcode). Registers sample on the edge that ends the
//  T-state, so IR loaded at the end of T3 is decoded in T4.
//  Fetch, all opcodes:
//   T1: pc_out_n = 0, mar_load_n = 0
//   T2: pc_inc = 1
//   T3: ram_out_n = 0, ir_load_n = 0
//  Execute (only the listed bits are asserted; unlisted T-states output CW_IDLE):
//   LDA 4'h0: T4 ir_out_n, mar_load_n | T5 ram_out_n, a_load_n
//   ADD 4'h1: T4 ir_out_n, mar_load_n | T5 ram_out_n, b_load_n | T6 alu_out_n, a_load_n
//   SUB 4'h2: same as ADD, with alu_sub = 1 in T6 only
//   OUT 4'hE: T4 a_out_n, out_load_n
//   HLT 4'hF: at T4, cw = CW_IDLE. The edge ending T4 enters HALT: tstate = 0, halted = 1,
//             cw = CW_IDLE. HALT exits only through clr_n; run is ignored.
//   Any other opcode: NOP, T4..T6 = CW_IDLE; the ring still runs through T6.
//  Invariant, every cycle: at most one of {pc_out_n, ram_out_n, ir_out_n, a_out_n, alu_out_n} is 0.
//  Latency: every instruction takes exactly 6 clocks (HLT: 4 clocks to HALT). No early T-state skip.
// STRUCTURE
//  Shared package sap_ctrl_pkg: CW_W, cw bit-index localparams, CW_IDLE, opcode localparams
//   (OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT), T-state encodings.
//  One sub-module, sap_tstate_ring: 6-phase ring counter with run/idle/halt handling.
//   The top level adds the combinational opcode/T-state decoder.
// TESTING
//  1. clr_n = 0 at t = 0, then release with run = 0 -> cw = 12'h7FD, tstate = 0,
//     halted = 0; stays idle for 5 clocks.
//  2. run = 1, opcode = 4'h0 -> T1 cw = 12'h1FD (pc_out_n = mar_load_n = 0); T2 pc_inc = 1;
//     T3 ram_out_n = ir_load_n = 0; T4 ir_out_n = mar_load_n = 0; T5 ram_out_n = a_load_n = 0;
//     T6 cw = CW_IDLE; next edge tstate = 1.
//  3. opcode = 4'h2 -> T5 b_load_n = 0; T6 alu_out_n = a_load_n = 0, alu_sub = 1;
//     alu_sub = 0 in every other T-state.
//  4. opcode = 4'hF at T4 -> next edge halted = 1, tstate = 0; toggle run 0/1 for 10 clocks ->
//     no change until clr_n pulse.
//  5. Drop run = 0 at T2 of an ADD -> T3..T6 complete normally, then IDLE (tstate = 0).
//     Also assert clr_n = 0 mid-T5 -> cw = CW_IDLE within the same cycle, no clock needed.
//  6. Random opcodes and run pattern, 2000 cycles; assertion checks the one-driver invariant and
//     tstate in 0..6 on every cycle.

Source files
------------

// File: rtl/sap_ctrl_pkg.sv
// rtl/sap_ctrl_pkg.sv - shared constants, control-word bit map and state types for the SAP-U sequencer
package sap_ctrl_pkg;

  localparam int OPW    = 4;
  localparam int CW_W   = 12;
  localparam int T_LAST = 6;

  // Control-word bit indices, MSB..LSB
  localparam int CW_PC_INC     = 11;
  localparam int CW_PC_OUT_N   = 10;
  localparam int CW_MAR_LOAD_N = 9;
  localparam int CW_RAM_OUT_N  = 8;
  localparam int CW_IR_LOAD_N  = 7;
  localparam int CW_IR_OUT_N   = 6;
  localparam int CW_A_LOAD_N   = 5;
  localparam int CW_A_OUT_N    = 4;
  localparam int CW_B_LOAD_N   = 3;
  localparam int CW_ALU_OUT_N  = 2;
  localparam int CW_ALU_SUB    = 1;
  localparam int CW_OUT_LOAD_N = 0;

  // Every active-low pin released, incrementer and subtract off
  localparam logic [CW_W-1:0] CW_IDLE = 12'b0111_1111_1101;

  localparam logic [OPW-1:0] OP_LDA = 4'h0;
  localparam logic [OPW-1:0] OP_ADD = 4'h1;
  localparam logic [OPW-1:0] OP_SUB = 4'h2;
  localparam logic [OPW-1:0] OP_OUT = 4'hE;
  localparam logic [OPW-1:0] OP_HLT = 4'hF;

  // T-state encodings as seen on the tstate output; 0 means not running
  localparam logic [2:0] T_IDLE = 3'd0;
  localparam logic [2:0] T1     = 3'd1;
  localparam logic [2:0] T2     = 3'd2;
  localparam logic [2:0] T3     = 3'd3;
  localparam logic [2:0] T4     = 3'd4;
  localparam logic [2:0] T5     = 3'd5;
  localparam logic [2:0] T6     = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } seq_state_e;

endpackage

// File: rtl/sap_control_sequencer_if.sv
// rtl/sap_control_sequencer_if.sv - run/opcode in, control word and status out of the sequencer
interface sap_control_sequencer_if;
  import sap_ctrl_pkg::*;

  logic            run;
  logic [OPW-1:0]  opcode;
  logic [CW_W-1:0] cw;
  logic [2:0]      tstate;
  logic            halted;

  // The sequencer owns the control word and status
  modport master (
    input  run,
    input  opcode,
    output cw,
    output tstate,
    output halted
  );

  // The machine side supplies run and the IR opcode nibble
  modport slave (
    output run,
    output opcode,
    input  cw,
    input  tstate,
    input  halted
  );

endinterface

// File: rtl/sap_tstate_ring.sv
// rtl/sap_tstate_ring.sv - six-phase T-state ring with idle, run and halt handling
module sap_tstate_ring
  import sap_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       clr_n,
  input  logic       run,
  input  logic       hlt_req,
  output seq_state_e state,
  output logic [2:0] tstate
);

  seq_state_e state_q, state_d;
  logic [2:0] t_q, t_d;

  // State and T-state registers; clear drops straight back to idle even mid-instruction
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
      t_q     <= T_IDLE;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
    end
  end

  // Next state: run is only sampled at instruction boundaries, halt is sticky until clear
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    unique case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_RUN;
          t_d     = T1;
        end
      end
      ST_RUN: begin
        if (t_q == T4 && hlt_req) begin
          state_d = ST_HALT;
          t_d     = T_IDLE;
        end else if (t_q == 3'(T_LAST)) begin
          if (run) begin
            t_d = T1;
          end else begin
            state_d = ST_IDLE;
            t_d     = T_IDLE;
          end
        end else begin
          t_d = t_q + 3'd1;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
        t_d     = T_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        t_d     = T_IDLE;
      end
    endcase
  end

  assign state  = state_q;
  assign tstate = t_q;

endmodule

// File: rtl/sap_control_sequencer.sv
// rtl/sap_control_sequencer.sv - SAP-U T-state controller: ring counter plus opcode/T-state decoder
module sap_control_sequencer
  import sap_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    clr_n,
  sap_control_sequencer_if.master bus
);

  seq_state_e      state;
  logic [2:0]      tstate;
  logic            hlt_req;
  logic [CW_W-1:0] cw_d;

  assign hlt_req = (bus.opcode == OP_HLT);

  sap_tstate_ring u_ring (
    .clk     (clk),
    .clr_n   (clr_n),
    .run     (bus.run),
    .hlt_req (hlt_req),
    .state   (state),
    .tstate  (tstate)
  );

  // Control-word decode; each T-state enables at most one bus driver
  always_comb begin
    cw_d = CW_IDLE;
    if (state == ST_RUN) begin
      unique case (tstate)
        T1: begin
          cw_d[CW_PC_OUT_N]   = 1'b0;
          cw_d[CW_MAR_LOAD_N] = 1'b0;
        end
        T2: begin
          cw_d[CW_PC_INC] = 1'b1;
        end
        T3: begin
          cw_d[CW_RAM_OUT_N] = 1'b0;
          cw_d[CW_IR_LOAD_N] = 1'b0;
        end
        T4: begin
          if (bus.opcode == OP_LDA || bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            cw_d[CW_IR_OUT_N]   = 1'b0;
            cw_d[CW_MAR_LOAD_N] = 1'b0;
          end else if (bus.opcode == OP_OUT) begin
            cw_d[CW_A_OUT_N]    = 1'b0;
            cw_d[CW_OUT_LOAD_N] = 1'b0;
          end
        end
        T5: begin
          if (bus.opcode == OP_LDA) begin
            cw_d[CW_RAM_OUT_N] = 1'b0;
            cw_d[CW_A_LOAD_N]  = 1'b0;
          end else if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            cw_d[CW_RAM_OUT_N] = 1'b0;
            cw_d[CW_B_LOAD_N]  = 1'b0;
          end
        end
        T6: begin
          if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            cw_d[CW_ALU_OUT_N] = 1'b0;
            cw_d[CW_A_LOAD_N]  = 1'b0;
            cw_d[CW_ALU_SUB]   = (bus.opcode == OP_SUB);
          end
        end
        default: cw_d = CW_IDLE;
      endcase
    end
  end

  assign bus.cw     = cw_d;
  assign bus.tstate = tstate;
  assign bus.halted = (state == ST_HALT);

endmodule
